// File: rtl/demux_1to3_stream_pkg.sv
// Shared constants for the 1-to-3 stream demux and the producers of select_i:
// channel select encodings, delivery counter width, slot state encoding and
// the select-to-channel decode.
package demux_1to3_stream_pkg;

    localparam logic [1:0] SEL_CH0 = 2'b00;
    localparam logic [1:0] SEL_CH1 = 2'b01;
    localparam logic [1:0] SEL_CH2 = 2'b10;

    localparam int CNT_W  = 8;
    localparam int NUM_CH = 3;

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_e;

    // One-hot channel decode; the unused encoding 2'b11 also lands on channel 2.
    function automatic logic [NUM_CH-1:0] sel_decode(input logic [1:0] sel);
        logic [NUM_CH-1:0] oh;
        case (sel)
            SEL_CH0: oh = 3'b001;
            SEL_CH1: oh = 3'b010;
            SEL_CH2: oh = 3'b100;
            default: oh = 3'b100;
        endcase
        return oh;
    endfunction

endpackage

// File: rtl/demux_1to3_stream_slot.sv
// One-word channel slot: EMPTY/FULL state, data register and a wrapping
// delivery counter. The state is exported so the parent derives valid from it.
module demux_slot
    import demux_1to3_stream_pkg::*;
#(
    parameter int size = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              flush_i,
    input  logic              load_i,
    input  logic              ready_i,
    input  logic [size-1:0]   data_i,
    output slot_state_e       state_o,
    output logic [size-1:0]   data_o,
    output logic [CNT_W-1:0]  cnt_o
);

    slot_state_e       state_q, state_d;
    logic [size-1:0]   data_q, data_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              drain;

    // A delivery happens whenever the slot holds a word and the consumer accepts.
    always_comb drain = (state_q == SLOT_FULL) && ready_i;

    // Next state: flush wins; otherwise a load overrides a drain so a
    // simultaneous drain+load keeps the slot full with the new word.
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        if (flush_i) begin
            state_d = SLOT_EMPTY;
        end else begin
            if (drain) begin
                state_d = SLOT_EMPTY;
                cnt_d   = cnt_q + CNT_W'(1);
            end
            if (load_i) begin
                state_d = SLOT_FULL;
                data_d  = data_i;
            end
        end
    end

    // State, data and counter registers; reset discards any held word.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= SLOT_EMPTY;
            data_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
        end
    end

    assign state_o = state_q;
    assign data_o  = data_q;
    assign cnt_o   = cnt_q;

endmodule

// File: rtl/demux_1to3_stream.sv
// 1-to-3 stream demultiplexer with a one-word slot per channel.
// Handshake: a word moves across an interface on a rising edge where valid
// and ready are both 1. valid, once raised, holds with stable data until that
// transfer; in_ready_o is combinational (select, flush, channel readies) and
// allows a load into a slot that is draining on the same edge.
module demux_1to3_stream
    import demux_1to3_stream_pkg::*;
#(
    parameter int size = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              flush_i,
    input  logic [size-1:0]   data_i,
    input  logic [1:0]        select_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    output logic [size-1:0]   data0_o,
    output logic [size-1:0]   data1_o,
    output logic [size-1:0]   data2_o,
    output logic              valid0_o,
    output logic              valid1_o,
    output logic              valid2_o,
    input  logic              ready0_i,
    input  logic              ready1_i,
    input  logic              ready2_i,
    output logic [CNT_W-1:0]  cnt0_o,
    output logic [CNT_W-1:0]  cnt1_o,
    output logic [CNT_W-1:0]  cnt2_o,
    output logic              busy_o
);

    logic [NUM_CH-1:0]             sel_oh;
    logic [NUM_CH-1:0]             ready_vec;
    logic [NUM_CH-1:0]             full_vec;
    logic [NUM_CH-1:0]             load_vec;
    logic [NUM_CH-1:0][size-1:0]   data_vec;
    logic [NUM_CH-1:0][CNT_W-1:0]  cnt_vec;
    slot_state_e                   state_vec [NUM_CH];

    assign ready_vec = {ready2_i, ready1_i, ready0_i};

    // Decode the destination; accept when it is empty or draining this cycle,
    // never during flush or reset.
    always_comb begin
        sel_oh     = sel_decode(select_i);
        in_ready_o = rst_i && !flush_i && (|(sel_oh & (~full_vec | ready_vec)));
        load_vec   = (in_valid_i && in_ready_o) ? sel_oh : '0;
    end

    for (genvar k = 0; k < NUM_CH; k++) begin : g_slot
        demux_slot #(.size(size)) u_slot (
            .clk_i   (clk_i),
            .rst_i   (rst_i),
            .flush_i (flush_i),
            .load_i  (load_vec[k]),
            .ready_i (ready_vec[k]),
            .data_i  (data_i),
            .state_o (state_vec[k]),
            .data_o  (data_vec[k]),
            .cnt_o   (cnt_vec[k])
        );
        assign full_vec[k] = (state_vec[k] == SLOT_FULL);
    end

    // Fan the per-channel vectors out to the named ports.
    always_comb begin
        valid0_o = full_vec[0];
        valid1_o = full_vec[1];
        valid2_o = full_vec[2];
        data0_o  = data_vec[0];
        data1_o  = data_vec[1];
        data2_o  = data_vec[2];
        cnt0_o   = cnt_vec[0];
        cnt1_o   = cnt_vec[1];
        cnt2_o   = cnt_vec[2];
        busy_o   = |full_vec;
    end

endmodule

// File: tb/tb_demux_1to3_stream.sv
// Directed bench for demux_1to3_stream: reset, routing, backpressure,
// channel independence, flush, counter wrap and mid-stream reset.
module tb_demux_1to3_stream;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        flush_i;
    logic [31:0] data_i;
    logic [1:0]  select_i;
    logic        in_valid_i;
    logic        in_ready_o;
    logic [31:0] data0_o, data1_o, data2_o;
    logic        valid0_o, valid1_o, valid2_o;
    logic        ready0_i, ready1_i, ready2_i;
    logic [7:0]  cnt0_o, cnt1_o, cnt2_o;
    logic        busy_o;

    int pass_cnt  = 0;
    int fail_cnt  = 0;
    int total_cnt = 0;

    demux_1to3_stream dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .flush_i    (flush_i),
        .data_i     (data_i),
        .select_i   (select_i),
        .in_valid_i (in_valid_i),
        .in_ready_o (in_ready_o),
        .data0_o    (data0_o),
        .data1_o    (data1_o),
        .data2_o    (data2_o),
        .valid0_o   (valid0_o),
        .valid1_o   (valid1_o),
        .valid2_o   (valid2_o),
        .ready0_i   (ready0_i),
        .ready1_i   (ready1_i),
        .ready2_i   (ready2_i),
        .cnt0_o     (cnt0_o),
        .cnt1_o     (cnt1_o),
        .cnt2_o     (cnt2_o),
        .busy_o     (busy_o)
    );

    // Clock: 10 time-unit period, rising edges at 5, 15, 25, ...
    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) begin
            pass_cnt++;
        end else begin
            fail_cnt++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    // Present an input word and let combinational outputs settle.
    task automatic drive(input logic v, input logic [1:0] s, input logic [31:0] d);
        in_valid_i = v;
        select_i   = s;
        data_i     = d;
        #1;
    endtask

    initial begin
        rst_i = 1'b0; flush_i = 1'b0; data_i = '0; select_i = '0; in_valid_i = 1'b0;
        ready0_i = 1'b0; ready1_i = 1'b0; ready2_i = 1'b0;

        // Reset state
        #3;
        check("rst_valid0", valid0_o, 0);
        check("rst_valid1", valid1_o, 0);
        check("rst_valid2", valid2_o, 0);
        check("rst_busy", busy_o, 0);
        check("rst_cnt0", cnt0_o, 0);
        check("rst_in_ready", in_ready_o, 0);
        check("rst_data0", data0_o, 0);
        step();
        rst_i = 1'b1;
        step();

        // Routing with all channels ready
        ready0_i = 1'b1; ready1_i = 1'b1; ready2_i = 1'b1;
        drive(1, 2'd0, 32'hA0);
        check("route_in_ready", in_ready_o, 1);
        step();
        check("route_valid0", valid0_o, 1);
        check("route_data0", data0_o, 32'hA0);
        drive(1, 2'd1, 32'hA1);
        step();
        check("route_valid0_drained", valid0_o, 0);
        check("route_cnt0", cnt0_o, 1);
        check("route_valid1", valid1_o, 1);
        check("route_data1", data1_o, 32'hA1);
        drive(1, 2'd2, 32'hA2);
        step();
        check("route_valid2_a2", valid2_o, 1);
        check("route_data2_a2", data2_o, 32'hA2);
        check("route_cnt1", cnt1_o, 1);
        drive(1, 2'd3, 32'hA3);
        step();
        check("route_valid2_a3", valid2_o, 1);
        check("route_data2_a3", data2_o, 32'hA3);
        check("route_cnt2_a", cnt2_o, 1);
        drive(0, 2'd0, 32'h0);
        step();
        check("route_valid2_drained", valid2_o, 0);
        check("route_cnt2_b", cnt2_o, 2);
        check("route_busy_idle", busy_o, 0);

        // Backpressure on channel 1
        ready1_i = 1'b0;
        drive(1, 2'd1, 32'h11);
        check("bp_in_ready_first", in_ready_o, 1);
        step();
        check("bp_valid1", valid1_o, 1);
        check("bp_data1_11", data1_o, 32'h11);
        drive(1, 2'd1, 32'h22);
        check("bp_in_ready_stalled", in_ready_o, 0);
        step();
        check("bp_data1_held", data1_o, 32'h11);
        check("bp_cnt1_held", cnt1_o, 1);
        ready1_i = 1'b1;
        #1;
        check("bp_in_ready_draining", in_ready_o, 1);
        step();
        check("bp_valid1_b2b", valid1_o, 1);
        check("bp_data1_22", data1_o, 32'h22);
        check("bp_cnt1_a", cnt1_o, 2);
        drive(0, 2'd0, 32'h0);
        step();
        check("bp_valid1_drained", valid1_o, 0);
        check("bp_cnt1_b", cnt1_o, 3);

        // Stalled channel 0 must not block channel 2
        ready0_i = 1'b0;
        drive(1, 2'd0, 32'h55);
        step();
        check("ind_valid0", valid0_o, 1);
        drive(1, 2'd2, 32'h77);
        check("ind_in_ready", in_ready_o, 1);
        step();
        check("ind_valid2", valid2_o, 1);
        check("ind_data2", data2_o, 32'h77);
        check("ind_data0_hold_a", data0_o, 32'h55);
        drive(0, 2'd0, 32'h0);
        step();
        check("ind_valid2_drained", valid2_o, 0);
        check("ind_cnt2", cnt2_o, 3);
        check("ind_valid0_stays", valid0_o, 1);
        check("ind_data0_hold_b", data0_o, 32'h55);
        check("ind_cnt0", cnt0_o, 1);

        // Flush with all slots full and an input offered
        ready1_i = 1'b0; ready2_i = 1'b0;
        drive(1, 2'd1, 32'h66);
        step();
        drive(1, 2'd2, 32'h88);
        step();
        check("fl_pre_valid1", valid1_o, 1);
        check("fl_pre_valid2", valid2_o, 1);
        ready0_i = 1'b1; ready1_i = 1'b1; ready2_i = 1'b1;
        flush_i = 1'b1;
        drive(1, 2'd0, 32'h99);
        check("fl_in_ready", in_ready_o, 0);
        step();
        flush_i = 1'b0;
        drive(0, 2'd0, 32'h0);
        check("fl_valid0", valid0_o, 0);
        check("fl_valid1", valid1_o, 0);
        check("fl_valid2", valid2_o, 0);
        check("fl_cnt0", cnt0_o, 1);
        check("fl_cnt1", cnt1_o, 3);
        check("fl_cnt2", cnt2_o, 3);
        check("fl_data0_not_loaded", data0_o, 32'h55);

        // Counter wrap on channel 1 (starts at 3)
        for (int i = 0; i < 252; i++) begin
            drive(1, 2'd1, 32'(i));
            step();
            check("wrap_stream_data1", data1_o, 32'(i));
        end
        drive(0, 2'd0, 32'h0);
        step();
        check("wrap_cnt1_255", cnt1_o, 255);
        check("wrap_valid1_empty", valid1_o, 0);
        drive(1, 2'd1, 32'h100);
        step();
        drive(0, 2'd0, 32'h0);
        step();
        check("wrap_cnt1_0", cnt1_o, 0);
        drive(1, 2'd1, 32'h101);
        step();
        drive(0, 2'd0, 32'h0);
        step();
        check("wrap_cnt1_1", cnt1_o, 1);

        // Asynchronous reset mid-stream with all slots full
        ready0_i = 1'b0; ready1_i = 1'b0; ready2_i = 1'b0;
        drive(1, 2'd0, 32'hC0);
        step();
        drive(1, 2'd1, 32'hC1);
        step();
        drive(1, 2'd2, 32'hC2);
        step();
        check("mrst_pre_busy", busy_o, 1);
        #1;
        rst_i = 1'b0;
        #1;
        check("mrst_valid0", valid0_o, 0);
        check("mrst_valid1", valid1_o, 0);
        check("mrst_valid2", valid2_o, 0);
        check("mrst_cnt0", cnt0_o, 0);
        check("mrst_cnt1", cnt1_o, 0);
        check("mrst_cnt2", cnt2_o, 0);
        check("mrst_in_ready", in_ready_o, 0);
        check("mrst_data2", data2_o, 0);
        check("mrst_busy", busy_o, 0);
        step();
        rst_i = 1'b1;
        ready0_i = 1'b1; ready1_i = 1'b1; ready2_i = 1'b1;
        drive(1, 2'd1, 32'hD1);
        step();
        check("mrst_resume_valid1", valid1_o, 1);
        check("mrst_resume_data1", data1_o, 32'hD1);
        drive(0, 2'd0, 32'h0);
        step();
        check("mrst_resume_cnt1", cnt1_o, 1);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
